// File: rtl/fifo_pkg.sv
// Shared defaults, count-width helper and parameter legality check for the
// parametrised synchronous FIFO.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_ADDR_WIDTH = 4;
  localparam int FIFO_AF_THRESH  = 14;
  localparam int FIFO_AE_THRESH  = 2;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // count must hold 0..DEPTH inclusive, hence one bit more than a pointer
  function automatic int fifo_count_width(input int addr_width);
    return addr_width + 32'sd1;
  endfunction

  function automatic bit fifo_params_ok(input int addr_width, input int af_thresh,
                                        input int ae_thresh);
    int depth;
    depth = 32'sd1 << addr_width;
    return (af_thresh >= 32'sd1) && (af_thresh <= depth) &&
           (ae_thresh >= 32'sd0) && (ae_thresh <= depth - 32'sd1);
  endfunction

endpackage

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and error-pulse control for fifo_sync_param.
// Optional flush input when FIFO_FLUSH_EN is defined.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int AF_THRESH  = FIFO_AF_THRESH,
  parameter int AE_THRESH  = FIFO_AE_THRESH
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef FIFO_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  wr,
  input  logic                  rd,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CW    = fifo_count_width(ADDR_WIDTH);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]         AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0]         AE_C    = CW'(AE_THRESH);
  localparam logic [CW-1:0]         CNT_ONE = CW'(1'b1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1'b1);

  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic                  overflow_r;
  logic                  underflow_r;
  logic                  push;
  logic                  pop;
  fifo_op_e              op;

  // Flags are decoded from count only, so they can never disagree with it
  assign full         = (count_r == DEPTH_C);
  assign empty        = (count_r == {CW{1'b0}});
  assign almost_full  = (count_r >= AF_C);
  assign almost_empty = (count_r <= AE_C);

  // Accept decisions; a pop on a full FIFO frees the slot the push fills
  always_comb begin
    push = wr && (!full || rd);
    pop  = rd && !empty;
    op   = fifo_op_e'({pop, push});
  end

  // Pointer, count and error-pulse state
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= {ADDR_WIDTH{1'b0}};
      rd_ptr_r    <= {ADDR_WIDTH{1'b0}};
      count_r     <= {CW{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end
`ifdef FIFO_FLUSH_EN
    else if (flush) begin
      wr_ptr_r    <= {ADDR_WIDTH{1'b0}};
      rd_ptr_r    <= {ADDR_WIDTH{1'b0}};
      count_r     <= {CW{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end
`endif
    else begin
      if (push) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case (op)
        OP_PUSH: count_r <= count_r + CNT_ONE;
        OP_POP:  count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      overflow_r  <= wr && full && !rd;
      underflow_r <= rd && empty;
    end
  end

  assign wr_en     = push;
  assign wr_addr   = wr_ptr_r;
  assign rd_addr   = rd_ptr_r;
  assign count     = count_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock first-word-fall-through FIFO.
// Define FIFO_FLUSH_EN to add a synchronous flush input after rst.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int AF_THRESH  = FIFO_AF_THRESH,
  parameter int AE_THRESH  = FIFO_AE_THRESH
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef FIFO_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] w_Data,
  output logic [DATA_WIDTH-1:0] r_Data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (!fifo_params_ok(ADDR_WIDTH, AF_THRESH, AE_THRESH)) begin : g_param_check
    $error("fifo_sync_param: AF_THRESH/AE_THRESH out of range for ADDR_WIDTH");
  end

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  fifo_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .AF_THRESH  (AF_THRESH),
    .AE_THRESH  (AE_THRESH)
  ) u_ctrl (
    .clk          (clk),
    .rst          (rst),
`ifdef FIFO_FLUSH_EN
    .flush        (flush),
`endif
    .wr           (wr),
    .rd           (rd),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .rd_addr      (rd_addr),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Storage array; deliberately not reset, contents are qualified by count
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= w_Data;
  end

  assign r_Data = mem[rd_addr];

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param: queue scoreboard plus flag model.
module tb_fifo_sync_param;

  localparam int DEPTH = 16;
`ifdef FIFO_FLUSH_EN
  localparam bit FL_EN = 1'b1;
`else
  localparam bit FL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       wr;
  logic       rd;
  logic [7:0] w_Data;
  logic [7:0] r_Data;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
`ifdef FIFO_FLUSH_EN
  logic       flush;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] q[$];
  logic exp_ovf = 1'b0;
  logic exp_unf = 1'b0;

  fifo_sync_param dut (
    .clk          (clk),
    .rst          (rst),
`ifdef FIFO_FLUSH_EN
    .flush        (flush),
`endif
    .wr           (wr),
    .rd           (rd),
    .w_Data       (w_Data),
    .r_Data       (r_Data),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    int m;
    m = q.size();
    check_val("count", 32'(count), 32'(m));
    check_val("full", 32'(full), 32'(m == DEPTH));
    check_val("empty", 32'(empty), 32'(m == 0));
    check_val("almost_full", 32'(almost_full), 32'(m >= 14));
    check_val("almost_empty", 32'(almost_empty), 32'(m <= 2));
    check_val("overflow", 32'(overflow), 32'(exp_ovf));
    check_val("underflow", 32'(underflow), 32'(exp_unf));
    if (m > 0) check_val("head", 32'(r_Data), 32'(q[0]));
  endtask

  // One clock of stimulus: predict, compare popped data, advance, check state
  task automatic step(input logic w, input logic r, input logic [7:0] d,
                      input logic rs, input logic fl);
    int   m;
    logic push_ok, pop_ok;
    wr = w; rd = r; w_Data = d; rst = rs;
`ifdef FIFO_FLUSH_EN
    flush = fl;
`endif
    m = q.size();
    if (rs || (FL_EN && fl)) begin
      q.delete();
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
      push_ok = w && ((m < DEPTH) || r);
      pop_ok  = r && (m > 0);
      exp_ovf = w && (m == DEPTH) && !r;
      exp_unf = r && (m == 0);
      if (pop_ok) check_val("pop_data", 32'(r_Data), 32'(q.pop_front()));
      if (push_ok) q.push_back(d);
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  initial begin
    wr = 1'b0; rd = 1'b0; w_Data = 8'h00; rst = 1'b1;
`ifdef FIFO_FLUSH_EN
    flush = 1'b0;
`endif
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Fill past full: 17th push rejected with overflow pulse
    for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Drain past empty: 17th pop rejected with underflow pulse
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Simultaneous push/pop starting empty
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

    // Full plus simultaneous push/pop, then drain so 0xA5 emerges last
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

    // Pointer wrap
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h80 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

    // Mid-stream reset at count 7 overrides a push
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'(8'h20 + i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'hEE, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

`ifdef FIFO_FLUSH_EN
    // Flush with push: push dropped, count cleared, no error pulses
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h30 + i), 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h77, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
`endif

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
           1'b0, FL_EN && ($urandom_range(0, 31) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
